// File: rtl/serial_twos_comp_mc.sv
// Multi-channel LSB-first serial two's-complementer with per-lane pass-through mode.
// Optional overflow detection is compiled in when STC_OVF_EN is defined.
module serial_twos_comp_mc #(
    parameter int CHANNELS  = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic                clk,
    input  logic                areset_n,
    input  logic                start,
    input  logic                valid_in,
    input  logic [CHANNELS-1:0] x,
    input  logic [CHANNELS-1:0] neg,
    output logic [CHANNELS-1:0] z,
    output logic                valid_out,
    output logic                last_out,
    output logic [CNT_W-1:0]    bit_idx,
    output logic [CHANNELS-1:0] ovf
);

    typedef enum logic {
        IDLE_ZERO = 1'b0,
        SEEN_ONE  = 1'b1
    } lane_state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    lane_state_e         state_q   [CHANNELS];
    lane_state_e         state_d   [CHANNELS];
    lane_state_e         state_eff [CHANNELS];

    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W-1:0]    cur_idx;
    logic                is_last;

    logic [CHANNELS-1:0] mode_q;
    logic [CHANNELS-1:0] mode_d;
    logic [CHANNELS-1:0] mode_eff;

    logic [CHANNELS-1:0] z_q;
    logic [CHANNELS-1:0] z_d;
    logic [CHANNELS-1:0] ovf_q;
    logic [CHANNELS-1:0] ovf_d;
    logic                valid_q;
    logic                valid_d;
    logic                last_q;
    logic                last_d;
    logic [CNT_W-1:0]    idx_q;
    logic [CNT_W-1:0]    idx_d;

    // start acts combinationally so a bit arriving with it is already bit 0 of a fresh frame
    always_comb begin
        cur_idx  = start ? '0 : cnt_q;
        is_last  = (cur_idx == LAST_IDX);
        mode_eff = (cur_idx == '0) ? neg : mode_q;
        for (int i = 0; i < CHANNELS; i++) begin
            state_eff[i] = start ? IDLE_ZERO : state_q[i];
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt_q  <= '0;
            mode_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE_ZERO;
            end
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        mode_d = mode_q;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
        end
        if (valid_in) begin
            cnt_d  = is_last ? '0 : cur_idx + CNT_W'(1);
            mode_d = mode_eff;
            for (int i = 0; i < CHANNELS; i++) begin
                if (is_last) begin
                    state_d[i] = IDLE_ZERO;
                end else if (state_eff[i] == IDLE_ZERO && x[i]) begin
                    state_d[i] = SEEN_ONE;
                end else begin
                    state_d[i] = state_eff[i];
                end
            end
        end else if (start) begin
            cnt_d = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_d[i] = IDLE_ZERO;
            end
        end
    end

    // Once a 1 has passed, every later bit of a negated word is inverted
    always_comb begin
        z_d     = z_q;
        valid_d = valid_in;
        last_d  = valid_in && is_last;
        idx_d   = valid_in ? cur_idx : idx_q;
        if (valid_in) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (mode_eff[i] && state_eff[i] == SEEN_ONE) begin
                    z_d[i] = ~x[i];
                end else begin
                    z_d[i] = x[i];
                end
            end
        end
    end

`ifdef STC_OVF_EN
    // A negated word of the most negative value reaches its MSB without any earlier 1
    always_comb begin
        ovf_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ovf_d[i] = valid_in && is_last && mode_eff[i] &&
                       (state_eff[i] == IDLE_ZERO) && x[i];
        end
    end
`else
    assign ovf_d = '0;
`endif

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            z_q     <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            z_q     <= z_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end

    assign z         = z_q;
    assign ovf       = ovf_q;
    assign valid_out = valid_q;
    assign last_out  = last_q;
    assign bit_idx   = idx_q;

endmodule

// File: doc/serial_twos_comp_mc.md
# serial_twos_comp_mc

Multi-channel serial two's-complementer for LSB-first bit streams, the parametrised successor to our single-channel serial negator FSM. Each of CHANNELS lanes receives one bit per valid cycle and emits either the two's complement or a pass-through copy of its word, one bit at a time, with a registered output. The block tracks frame boundaries with an internal bit counter, so states re-arm automatically between words. It sits between the serial front-end deserialiser and the per-lane accumulators.

## Interface
- CHANNELS, 4, number of independent serial lanes (1..32)
- FRAME_LEN, 8, bits per word (2..256)
- CNT_W, $clog2(FRAME_LEN), bit-counter width (derived, do not override)

- clk  input  1  rising-edge clock
- areset_n  input  1  asynchronous, active-low reset
- start  input  1  abort any frame in progress; next accepted bit is bit 0
- valid_in  input  1  x carries a valid bit this cycle
- x  input  CHANNELS  serial data, one bit per lane, LSB first
- neg  input  CHANNELS  per-lane mode: 1 = two's complement, 0 = pass-through
- z  output  CHANNELS  serial result, one bit per lane
- valid_out  output  1  z valid this cycle
- last_out  output  1  z carries bit FRAME_LEN-1 (MSB)
- bit_idx  output  CNT_W  index of the bit currently on z
- ovf  output  CHANNELS  per-lane overflow, valid only with last_out

## Operation
- Per lane, two states: IDLE_ZERO (no 1 seen yet this frame), SEEN_ONE.
- Negate lane: in IDLE_ZERO, z = x, go to SEEN_ONE if x=1; in SEEN_ONE, z = ~x, stay.
- Pass-through lane: z = x; state still updates (unused).
- neg is sampled per lane on bit 0 of each frame and held for the whole frame; mid-frame changes are ignored.
- Bit counter increments on each valid_in; on the bit where counter = FRAME_LEN-1, counter returns to 0 and all lanes return to IDLE_ZERO after that bit.
- valid_in=0: counter, states, latched modes hold; z holds its last value; valid_out=0.
- start=1: counter and all lane states cleared. If valid_in=1 in the same cycle, that bit is processed as bit 0 of a new frame (using current neg). start=1 and valid_in=0: frame aborted, no output.
- Overflow (negate lanes only): ovf=1 on the MSB bit when lane is in IDLE_ZERO and x=1 (input = -2^(FRAME_LEN-1)); otherwise 0. Pass-through lanes: ovf=0.

## Timing
- Reset values: z=0, valid_out=0, last_out=0, bit_idx=0, ovf=0; counter=0, all lanes IDLE_ZERO, latched mode=0.
- Latency: 1 cycle; bit accepted at edge N appears on z/valid_out/bit_idx after edge N.
- last_out and ovf asserted only in the cycle valid_out carries the MSB; cleared otherwise.
- Back-to-back frames sustain one bit per cycle; no idle cycle between frames.
- areset_n assertion mid-frame clears everything immediately (asynchronous); first valid bit after release is bit 0.
- start takes priority over frame-end wrap in the same cycle (both result in counter=0 for next bit).

## Configuration
- STC_OVF_EN defined: overflow detection logic present, ovf behaves as above.
- STC_OVF_EN undefined: detection logic omitted, ovf tied to all-zeros; all other behaviour identical.

## Test plan
- FRAME_LEN=8, lane0 neg=1, x=0x05 LSB first, continuous valid -> z=0xFB, last_out on 8th output bit, ovf=0.
- lane1 neg=1, x=0x80 -> z=0x80, ovf[1]=1 with last_out (0 when STC_OVF_EN undefined); lane2 neg=1, x=0x00 -> z=0x00, ovf=0.
- lane3 neg=0, x=0xA6; neg toggled to 1 at bit 3 -> z=0xA6 (mode held); next frame with neg=1, x=0x01 -> z=0xFF.
- Same 0x05 word with valid_in low for 3 cycles between bits 2 and 3 -> z=0xFB, valid_out gaps mirror input, bit_idx sequence 0..7.
- start pulsed with valid_in at bit 4 of a frame, then new word 0x03 -> new frame bit 0 aligned, z=0xFD, bit_idx restarts at 0.
- areset_n low for 1 cycle at bit 5 -> all outputs 0 immediately; following word 0x02 -> z=0xFE.
